nor_logic_sweep_checker: RTL and testbench
==========================================

Name: nor_logic_sweep_checker

Overview:
- Parametrised successor to the two-implementation gate comparisons in the lab set.
- Per op code, builds a WIDTH-bit bitwise function two ways: a network of 2-input/1-input NOR primitives ("gate" side) and a continuous-assign expression ("expr" side).
- An FSM sweeps every (a,b) operand pair, one vector per clock, and compares the two sides.
- It counts mismatches, captures the first failing vector and reports pass/fail, which replaces the hand-written $monitor tables with a self-checking block.

Parameters:
- WIDTH, 4, operand width per input, legal 1..6.
- NVEC, 2**(2*WIDTH), derived; number of vectors in a sweep. Not overridable.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  begin sweep; sampled only in IDLE or DONE.
- op  in  3  function select, latched on accepted start.
- inject  in  1  fault injection; while high in RUN, inverts bit 0 of the gate-side result.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- pass  out  1  valid when done=1; 1 iff err_count==0.
- a_out  out  WIDTH  operand a of the vector currently being compared.
- b_out  out  WIDTH  operand b of the vector currently being compared.
- s_gate  out  WIDTH  registered gate-side result for the compared vector.
- s_expr  out  WIDTH  registered expr-side result for the compared vector.
- err_count  out  2*WIDTH+1  number of mismatching vectors in the current or last sweep.
- first_valid  out  1  set at the first mismatch of a sweep.
- first_a  out  WIDTH  operand a of the first mismatch.
- first_b  out  WIDTH  operand b of the first mismatch.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
- Reset (rst_n=0 at a clk edge), which overrides everything including mid-RUN:
  - state=IDLE.
  - All outputs 0, except pass=0.
  - Vector index=0 and latched op=0.
- Op codes, all bitwise:
  - 000 NAND, 001 NOR, 010 AND, 011 OR, 100 XOR, 101 XNOR.
  - 110 NOT a (b ignored), 111 BUF a.
  - The gate side uses NOR primitives only; XOR/XNOR use standard NOR-only decompositions.
- FSM states are IDLE, RUN, DONE.
  - IDLE: start=1 latches op, clears err_count, first_valid, first_a and first_b, sets idx=0, and moves to RUN.
  - RUN: lasts exactly NVEC+1 cycles: NVEC issue cycles plus one drain cycle for the compare stage. start and op changes are ignored.
  - After the last compare, moves to DONE: done=1, pass=(err_count==0); done stays high.
  - DONE: start=1 behaves as in IDLE (restart). Otherwise the state holds, with all results frozen.
- Pipeline: 1-cycle latency.
  - Cycle k drives idx=k into both implementations.
  - Cycle k+1: a_out={idx[2W-1:W]}, b_out=idx[W-1:0], s_gate and s_expr show the registered results of vector k, and the compare updates err_count.
  - err_count, first_a and first_b reflect vector k one edge after s_gate and s_expr show it. This is a registered compare.
- inject is sampled in the issue cycle of a vector; the inverted bit travels with that vector.
- Mismatch means s_gate != s_expr, i.e. any bit differs.
  - Each mismatch increments err_count by 1.
  - The count cannot overflow (max NVEC < 2^(2W+1)); no saturation logic.
- first_a, first_b and first_valid load only on the first mismatch of a sweep; later mismatches do not overwrite them.
- Index wrap: idx reaches NVEC-1 and then stops. It does not wrap into a second sweep.
- Simultaneous start and reset: reset wins.
- busy and done are never both 1.

Test Plan:
- WIDTH=2, op=000, no inject, start pulse:
  - busy high for 17 cycles, then done=1, pass=1, err_count=0, first_valid=0.
  - At the vector a=11, b=11, both s_gate and s_expr show 00.
- WIDTH=2, op=100, inject high only during the issue cycle of idx=5:
  - err_count=1, first_valid=1, first_a=01, first_b=01, pass=0.
  - s_gate=01 and s_expr=00 at that compare.
- WIDTH=2, op=110, inject held high for the whole sweep → err_count=16, first_a=00, first_b=00, pass=0.
- WIDTH=3, op=101, start reasserted mid-RUN and op changed to 000 → ignored: sweep completes in 65 cycles with XNOR results, pass=1.
- Reset mid-RUN at idx=7, then start with op=011 → all outputs return to 0; the fresh sweep begins at idx=0 with err_count=0; done after 17 cycles (WIDTH=2), pass=1.
- Restart from DONE after a failing sweep → err_count and first_valid clear on the accepted start; a clean sweep ends with pass=1.

Source files
------------

// File: rtl/nor_logic_sweep_checker_if.sv
// nor_logic_sweep_checker_if: control and result bundle of the NOR sweep checker.
// Signals:
//   start        - begin a sweep (accepted in idle or done)
//   op           - function select, latched on an accepted start
//   inject       - inverts bit 0 of the gate-side result of the vector issued this cycle
//   busy / done  - sweep running / sweep finished (never both high)
//   pass         - valid with done; high when no vector mismatched
//   a_out, b_out - operands of the vector currently shown
//   s_gate       - registered NOR-network result for that vector
//   s_expr       - registered behavioural result for that vector
//   err_count    - mismatching vectors in the current or last sweep
//   first_*      - capture of the first mismatching vector of a sweep
interface nor_logic_sweep_checker_if #(
   parameter int unsigned WIDTH = 4
);
   logic               start;
   logic [2:0]         op;
   logic               inject;
   logic               busy;
   logic               done;
   logic               pass;
   logic [WIDTH-1:0]   a_out;
   logic [WIDTH-1:0]   b_out;
   logic [WIDTH-1:0]   s_gate;
   logic [WIDTH-1:0]   s_expr;
   logic [2*WIDTH:0]   err_count;
   logic               first_valid;
   logic [WIDTH-1:0]   first_a;
   logic [WIDTH-1:0]   first_b;

   modport master (
      output start, op, inject,
      input  busy, done, pass, a_out, b_out, s_gate, s_expr, err_count,
      input  first_valid, first_a, first_b
   );

   modport slave (
      input  start, op, inject,
      output busy, done, pass, a_out, b_out, s_gate, s_expr, err_count,
      output first_valid, first_a, first_b
   );
endinterface

// File: rtl/nor_logic_sweep_checker.sv
// nor_logic_sweep_checker: sweeps every (a,b) operand pair through a NOR-only gate network
// and a behavioural expression for the selected bitwise function, one vector per clock,
// and counts vectors where the two disagree.
// Ports:
//   clk_i  - clock, rising edge
//   rst_ni - synchronous active-low reset
//   bus_io - start/op/inject in; busy, done, pass, vector view, error count and
//            first-mismatch capture out
module nor_logic_sweep_checker #(
   parameter int unsigned WIDTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   nor_logic_sweep_checker_if.slave bus_io
);
   localparam int unsigned IdxW = 2 * WIDTH;
   localparam int unsigned CntW = IdxW + 1;

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e           state_q, state_d;
   logic [2:0]       op_q, op_d;
   logic [IdxW-1:0]  idx_q, idx_d;
   logic             drain_q, drain_d;
   logic             cmp_q, cmp_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [WIDTH-1:0] sg_q, sg_d, se_q, se_d;
   logic [WIDTH-1:0] fa_q, fa_d, fb_q, fb_d;
   logic [CntW-1:0]  err_q, err_d;
   logic             fv_q, fv_d;

   logic [WIDTH-1:0] opa, opb;
   logic [WIDTH-1:0] gate_res, expr_res;
   logic             issue, mismatch;

   // idx = {a, b}, so the sweep walks b fastest
   assign opa      = idx_q[IdxW-1:WIDTH];
   assign opb      = idx_q[WIDTH-1:0];
   assign issue    = (state_q == StRun) && !drain_q;
   assign mismatch = cmp_q && (sg_q != se_q);

   // Gate side: NOR primitives only
   logic [WIDTH-1:0] n_a, n_b, n_or, g_or, g_and, g_nand, x_a, x_b, g_xnor, g_xor, g_buf;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      nor u_not_a (n_a[i], opa[i]);
      nor u_not_b (n_b[i], opb[i]);
      nor u_nor   (n_or[i], opa[i], opb[i]);
      nor u_or    (g_or[i], n_or[i]);
      nor u_and   (g_and[i], n_a[i], n_b[i]);
      nor u_nand  (g_nand[i], g_and[i]);
      // XNOR = ~(x_a | x_b) with x_a = ~(a | ~(a|b)), x_b = ~(b | ~(a|b))
      nor u_x_a   (x_a[i], opa[i], n_or[i]);
      nor u_x_b   (x_b[i], opb[i], n_or[i]);
      nor u_xnor  (g_xnor[i], x_a[i], x_b[i]);
      nor u_xor   (g_xor[i], g_xnor[i]);
      nor u_buf   (g_buf[i], n_a[i]);
   end

   always_comb begin
      gate_res = '0;
      unique case (op_q)
         3'b000: gate_res = g_nand;
         3'b001: gate_res = n_or;
         3'b010: gate_res = g_and;
         3'b011: gate_res = g_or;
         3'b100: gate_res = g_xor;
         3'b101: gate_res = g_xnor;
         3'b110: gate_res = n_a;
         3'b111: gate_res = g_buf;
      endcase
   end

   // Expression side
   always_comb begin
      expr_res = '0;
      unique case (op_q)
         3'b000: expr_res = ~(opa & opb);
         3'b001: expr_res = ~(opa | opb);
         3'b010: expr_res = opa & opb;
         3'b011: expr_res = opa | opb;
         3'b100: expr_res = opa ^ opb;
         3'b101: expr_res = ~(opa ^ opb);
         3'b110: expr_res = ~opa;
         3'b111: expr_res = opa;
      endcase
   end

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      idx_d   = idx_q;
      drain_d = drain_q;
      cmp_d   = 1'b0;
      a_d     = a_q;
      b_d     = b_q;
      sg_d    = sg_q;
      se_d    = se_q;
      err_d   = err_q;
      fv_d    = fv_q;
      fa_d    = fa_q;
      fb_d    = fb_q;
      unique case (state_q)
         StIdle, StDone: begin
            if (bus_io.start) begin
               state_d = StRun;
               op_d    = bus_io.op;
               idx_d   = '0;
               drain_d = 1'b0;
               err_d   = '0;
               fv_d    = 1'b0;
               fa_d    = '0;
               fb_d    = '0;
            end
         end
         StRun: begin
            // Issue stage: register both results; inject rides along with this vector
            if (issue) begin
               a_d  = opa;
               b_d  = opb;
               sg_d = gate_res ^ WIDTH'(bus_io.inject);
               se_d = expr_res;
               if (&idx_q) drain_d = 1'b1;
               else        idx_d   = idx_q + IdxW'(1);
            end
            cmp_d = issue;
            // Compare stage: works on the vector registered last cycle
            if (mismatch) begin
               err_d = err_q + CntW'(1);
               if (!fv_q) begin
                  fv_d = 1'b1;
                  fa_d = a_q;
                  fb_d = b_q;
               end
            end
            // Drain cycle finishes the last compare
            if (drain_q) state_d = StDone;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         op_q    <= '0;
         idx_q   <= '0;
         drain_q <= 1'b0;
         cmp_q   <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sg_q    <= '0;
         se_q    <= '0;
         err_q   <= '0;
         fv_q    <= 1'b0;
         fa_q    <= '0;
         fb_q    <= '0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         idx_q   <= idx_d;
         drain_q <= drain_d;
         cmp_q   <= cmp_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sg_q    <= sg_d;
         se_q    <= se_d;
         err_q   <= err_d;
         fv_q    <= fv_d;
         fa_q    <= fa_d;
         fb_q    <= fb_d;
      end
   end

   assign bus_io.busy        = (state_q == StRun);
   assign bus_io.done        = (state_q == StDone);
   assign bus_io.pass        = (state_q == StDone) && (err_q == '0);
   assign bus_io.a_out       = a_q;
   assign bus_io.b_out       = b_q;
   assign bus_io.s_gate      = sg_q;
   assign bus_io.s_expr      = se_q;
   assign bus_io.err_count   = err_q;
   assign bus_io.first_valid = fv_q;
   assign bus_io.first_a     = fa_q;
   assign bus_io.first_b     = fb_q;
endmodule

// File: tb/tb_nor_logic_sweep_checker.sv
// Scoreboard bench for nor_logic_sweep_checker: a WIDTH=2 and a WIDTH=3 instance.
module tb_nor_logic_sweep_checker;
   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   nor_logic_sweep_checker_if #(.WIDTH(2)) if2 ();
   nor_logic_sweep_checker_if #(.WIDTH(3)) if3 ();

   nor_logic_sweep_checker #(.WIDTH(2)) u_dut2 (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus_io (if2.slave)
   );

   nor_logic_sweep_checker #(.WIDTH(3)) u_dut3 (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus_io (if3.slave)
   );

   typedef struct {
      int err;
      int first;     // {first_valid, first_a, first_b}
      int pass;
      int busy_len;
   } sum_t;

   logic [31:0] q2[$];
   logic [31:0] q3[$];
   sum_t        sq2[$];
   sum_t        sq3[$];

   int n_vec  = 0;
   int n_miss = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [5:0] model(input logic [2:0] op, input logic [5:0] a,
                                        input logic [5:0] b, input int w);
      logic [5:0] r;
      logic [5:0] m;
      m = 6'((1 << w) - 1);
      case (op)
         3'b000:  r = ~(a & b);
         3'b001:  r = ~(a | b);
         3'b010:  r = a & b;
         3'b011:  r = a | b;
         3'b100:  r = a ^ b;
         3'b101:  r = ~(a ^ b);
         3'b110:  r = ~a;
         default: r = a;
      endcase
      return r & m;
   endfunction

   task automatic drive(input int w, input logic st, input logic [2:0] op, input logic inj);
      if (w == 2) begin
         if2.start = st; if2.op = op; if2.inject = inj;
      end else begin
         if3.start = st; if3.op = op; if3.inject = inj;
      end
   endtask

   function automatic logic get_done(input int w);
      return (w == 2) ? if2.done : if3.done;
   endfunction

   // One sweep. inject is high for issue indices inj_lo..inj_hi; mid_k >= 0 raises start
   // and switches op to 000 from that index on; abort_k >= 0 resets at that issue cycle.
   task automatic run_sweep(input int w, input logic [2:0] op, input int inj_lo,
                            input int inj_hi, input int exp_err, input int exp_fa,
                            input int exp_fb, input int mid_k, input int abort_k);
      int          nvec;
      int          waited;
      logic [5:0]  a, b, e, g;
      logic        inj;
      logic [2:0]  op_drv;
      logic [31:0] v;
      sum_t        s;
      nvec = 1 << (2 * w);
      @(posedge clk); #1;
      drive(w, 1'b1, op, 1'b0);
      if (abort_k < 0) begin
         s.err      = exp_err;
         s.first    = (exp_err != 0) ? ((1 << (2 * w)) | (exp_fa << w) | exp_fb) : 0;
         s.pass     = (exp_err == 0) ? 1 : 0;
         s.busy_len = nvec + 1;
         if (w == 2) sq2.push_back(s);
         else        sq3.push_back(s);
      end
      @(posedge clk);
      op_drv = op;
      for (int k = 0; k < nvec; k++) begin
         #1;
         if (k == abort_k) begin
            rst_n = 1'b0;
            drive(w, 1'b0, op, 1'b0);
            q2.delete(); q3.delete(); sq2.delete(); sq3.delete();
            @(posedge clk);
            return;
         end
         inj = (k >= inj_lo) && (k <= inj_hi);
         if (mid_k >= 0 && k >= mid_k) op_drv = 3'b000;
         drive(w, k == mid_k, op_drv, inj);
         a = 6'(k >> w);
         b = 6'(k & ((1 << w) - 1));
         e = model(op, a, b, w);
         g = e ^ {5'b0, inj};
         v = (32'(a) << (3 * w)) | (32'(b) << (2 * w)) | (32'(g) << w) | 32'(e);
         if (w == 2) q2.push_back(v);
         else        q3.push_back(v);
         @(posedge clk);
      end
      #1 drive(w, 1'b0, op_drv, 1'b0);
      waited = 0;
      while (!get_done(w) && waited < 8) begin
         @(negedge clk);
         waited++;
      end
      chk("done_reached", 32'(get_done(w)), 32'd1);
   endtask

   // Monitor for the WIDTH=2 instance
   bit          bp2 = 1'b0, dp2 = 1'b0;
   int          blen2 = 0;
   always @(negedge clk) begin
      logic [31:0] ev;
      sum_t        s;
      if (!rst_n) begin
         bp2 = 1'b0; dp2 = 1'b0; blen2 = 0;
      end else begin
         if (if2.busy) begin
            if (!bp2) begin
               blen2 = 0;
               chk("w2_clear_on_start",
                   32'({if2.err_count, if2.first_valid, if2.first_a, if2.first_b}), 32'd0);
            end else if (q2.size() == 0) begin
               chk("w2_vec_underflow", 32'd1, 32'd0);
            end else begin
               ev = q2.pop_front();
               chk("w2_vec", 32'({if2.a_out, if2.b_out, if2.s_gate, if2.s_expr}), ev);
            end
            blen2++;
         end
         if (if2.done && !dp2) begin
            if (sq2.size() == 0) begin
               chk("w2_sum_underflow", 32'd1, 32'd0);
            end else begin
               s = sq2.pop_front();
               chk("w2_err_count", 32'(if2.err_count), 32'(s.err));
               chk("w2_first", 32'({if2.first_valid, if2.first_a, if2.first_b}), 32'(s.first));
               chk("w2_pass", 32'(if2.pass), 32'(s.pass));
               chk("w2_busy_len", 32'(blen2), 32'(s.busy_len));
               chk("w2_busy_done_excl", 32'(if2.busy & if2.done), 32'd0);
            end
         end
         bp2 = if2.busy;
         dp2 = if2.done;
      end
   end

   // Monitor for the WIDTH=3 instance
   bit          bp3 = 1'b0, dp3 = 1'b0;
   int          blen3 = 0;
   always @(negedge clk) begin
      logic [31:0] ev;
      sum_t        s;
      if (!rst_n) begin
         bp3 = 1'b0; dp3 = 1'b0; blen3 = 0;
      end else begin
         if (if3.busy) begin
            if (!bp3) begin
               blen3 = 0;
               chk("w3_clear_on_start",
                   32'({if3.err_count, if3.first_valid, if3.first_a, if3.first_b}), 32'd0);
            end else if (q3.size() == 0) begin
               chk("w3_vec_underflow", 32'd1, 32'd0);
            end else begin
               ev = q3.pop_front();
               chk("w3_vec", 32'({if3.a_out, if3.b_out, if3.s_gate, if3.s_expr}), ev);
            end
            blen3++;
         end
         if (if3.done && !dp3) begin
            if (sq3.size() == 0) begin
               chk("w3_sum_underflow", 32'd1, 32'd0);
            end else begin
               s = sq3.pop_front();
               chk("w3_err_count", 32'(if3.err_count), 32'(s.err));
               chk("w3_first", 32'({if3.first_valid, if3.first_a, if3.first_b}), 32'(s.first));
               chk("w3_pass", 32'(if3.pass), 32'(s.pass));
               chk("w3_busy_len", 32'(blen3), 32'(s.busy_len));
               chk("w3_busy_done_excl", 32'(if3.busy & if3.done), 32'd0);
            end
         end
         bp3 = if3.busy;
         dp3 = if3.done;
      end
   end

   task automatic check_reset_outputs();
      chk("w2_reset_outputs",
          32'({if2.busy, if2.done, if2.pass, if2.a_out, if2.b_out, if2.s_gate, if2.s_expr,
               if2.err_count, if2.first_valid, if2.first_a, if2.first_b}), 32'd0);
      chk("w3_reset_outputs",
          32'({if3.busy, if3.done, if3.pass, if3.a_out, if3.b_out, if3.s_gate, if3.s_expr,
               if3.err_count, if3.first_valid, if3.first_a, if3.first_b}), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      drive(2, 1'b0, 3'b000, 1'b0);
      drive(3, 1'b0, 3'b000, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs();
      rst_n = 1'b1;

      // NAND clean sweep: pass, a=11 b=11 gives 00 on both sides
      run_sweep(2, 3'b000, -1, -1, 0, 0, 0, -1, -1);
      // XOR with one injected fault at idx 5 (a=01, b=01)
      run_sweep(2, 3'b100, 5, 5, 1, 2'b01, 2'b01, -1, -1);
      // NOT a with inject held for the whole sweep
      run_sweep(2, 3'b110, 0, 15, 16, 0, 0, -1, -1);
      // Restart from DONE after the failing sweep: NOR, clean
      run_sweep(2, 3'b001, -1, -1, 0, 0, 0, -1, -1);
      // WIDTH=3 XNOR, start and op change mid-RUN are ignored
      run_sweep(3, 3'b101, -1, -1, 0, 0, 0, 20, -1);
      // Reset mid-RUN at idx 7
      run_sweep(2, 3'b100, -1, -1, 0, 0, 0, -1, 7);
      #1;
      check_reset_outputs();
      rst_n = 1'b1;
      // Fresh OR sweep after reset
      run_sweep(2, 3'b011, -1, -1, 0, 0, 0, -1, -1);

      repeat (2) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
